// File: rtl/minmax_tracker_pkg.sv
// Shared types for the min/max tracker slice.
// Comparator code points used by the tracker and its comparator.
package minmax_tracker_pkg;

  typedef enum logic [1:0] {
    CMP_EQ_Z    = 2'b00,
    CMP_LESS    = 2'b01,
    CMP_GREATER = 2'b10,
    CMP_EQ_NZ   = 2'b11
  } cmp_code_e;

  // Code of a value compared against itself.
  function automatic logic [1:0] self_code(input logic is_zero);
    return is_zero ? CMP_EQ_Z : CMP_EQ_NZ;
  endfunction

endpackage

// File: rtl/minmax_tracker_if.sv
// Sample stream and result bundle of the min/max tracker.
// master drives samples/control; slave is the tracker.
interface minmax_tracker_if #(
  parameter int p_WIDTH     = 8,
  parameter int p_CNT_WIDTH = 8
);

  logic                   i_valid;
  logic                   o_ready;
  logic [p_WIDTH-1:0]     i_data;
  logic                   i_last;
  logic                   i_ack;
  logic                   i_abort;
  logic                   o_done;
  logic [p_WIDTH-1:0]     o_max;
  logic [p_WIDTH-1:0]     o_min;
  logic [p_CNT_WIDTH-1:0] o_count;
  logic [1:0]             o_code;

  modport master (
    output i_valid, i_data, i_last,
    output i_ack, i_abort,
    input  o_ready, o_done,
    input  o_max, o_min,
    input  o_count, o_code
  );

  modport slave (
    input  i_valid, i_data, i_last,
    input  i_ack, i_abort,
    output o_ready, o_done,
    output o_max, o_min,
    output o_count, o_code
  );

endinterface

// File: rtl/CmpLgezNBit.sv
// Zero-aware N-bit unsigned magnitude comparator.
// 00 both zero, 01 x<y, 10 x>y, 11 equal non-zero.
module CmpLgezNBit
  import minmax_tracker_pkg::*;
#(
  parameter int p_WIDTH = 8
) (
  input  logic [p_WIDTH-1:0] i_x,
  input  logic [p_WIDTH-1:0] i_y,
  output logic [1:0]         o_code
);

  logic both_z;
  logic eq_nz;
  logic lt;
  logic gt;

  assign both_z = (i_x == '0) && (i_y == '0);
  assign eq_nz  = (i_x == i_y) && (i_x != '0);
  assign lt     = i_x < i_y;
  assign gt     = i_x > i_y;

  always_comb begin
    o_code = CMP_EQ_Z;
    unique case (1'b1)
      both_z:  o_code = CMP_EQ_Z;
      eq_nz:   o_code = CMP_EQ_NZ;
      lt:      o_code = CMP_LESS;
      gt:      o_code = CMP_GREATER;
      default: o_code = CMP_EQ_Z;
    endcase
  end

endmodule

// File: rtl/minmax_tracker.sv
// Framed streaming min/max accumulator with hold-until-ack results.
// Sits downstream of the zero-aware magnitude comparator.
module minmax_tracker
  import minmax_tracker_pkg::*;
#(
  parameter int p_WIDTH     = 8,
  parameter int p_CNT_WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  minmax_tracker_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e state_q;
  state_e state_d;

  logic [p_WIDTH-1:0]     max_q;
  logic [p_WIDTH-1:0]     min_q;
  logic [p_CNT_WIDTH-1:0] count_q;
  logic [1:0]             code_q;
  logic [1:0]             code_max;
  logic [1:0]             code_min;
  logic                   ready;
  logic                   done;
  logic                   accept;
  logic                   clear;

  CmpLgezNBit #(.p_WIDTH(p_WIDTH)) u_cmp_max (
    .i_x    (bus.i_data),
    .i_y    (max_q),
    .o_code (code_max)
  );

  CmpLgezNBit #(.p_WIDTH(p_WIDTH)) u_cmp_min (
    .i_x    (bus.i_data),
    .i_y    (min_q),
    .o_code (code_min)
  );

  assign accept = bus.i_valid && ready;
  assign clear  = bus.i_abort ||
                  ((state_q == HOLD) && bus.i_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.i_abort) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (accept)
                 state_d = bus.i_last ? HOLD : ACCUM;
        ACCUM: if (accept && bus.i_last)
                 state_d = HOLD;
        HOLD:  if (bus.i_ack)
                 state_d = EMPTY;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    ready = (state_q != HOLD);
    done  = (state_q == HOLD);
  end

  // Abort wins over accept, so a concurrent sample never lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q   <= '0;
      min_q   <= '0;
      count_q <= '0;
      code_q  <= CMP_EQ_Z;
    end else if (clear) begin
      max_q   <= '0;
      min_q   <= '0;
      count_q <= '0;
      code_q  <= CMP_EQ_Z;
    end else if (accept) begin
      if (state_q == EMPTY) begin
        max_q   <= bus.i_data;
        min_q   <= bus.i_data;
        count_q <= p_CNT_WIDTH'(1);
        code_q  <= self_code(bus.i_data == '0);
      end else begin
        code_q <= code_max;
        if (code_max == CMP_GREATER)
          max_q <= bus.i_data;
        if (code_min == CMP_LESS)
          min_q <= bus.i_data;
        if (count_q != '1)
          count_q <= count_q + p_CNT_WIDTH'(1);
      end
    end
  end

  assign bus.o_ready = ready;
  assign bus.o_done  = done;
  assign bus.o_max   = max_q;
  assign bus.o_min   = min_q;
  assign bus.o_count = count_q;
  assign bus.o_code  = code_q;

endmodule
